operand_fetch_stage: RTL and testbench

Parametrised operand-fetch pipeline stage with a valid/ready handshake on both sides. It sits between instruction fetch/decode and execute and drives the register-file read ports. A per-register pending-write scoreboard detects RAW hazards and stalls on them. Writeback data is forwarded into the operands, and the stage supports flush and downstream backpressure.

---
 rtl/operand_fetch_stage.sv | 174 +++++++++++++++++
 tb/tb_operand_fetch_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : operand_fetch_stage
//  Purpose  : Operand-fetch pipeline stage. Reads the register file, forwards
//             same-cycle writeback data, tracks pending writers per register
//             to stall on RAW / WAW-capacity hazards, and holds one
//             instruction in a valid/ready output register with flush.
//  Revision : 1.0  initial release
// ============================================================================
module operand_fetch_stage #(
  parameter  int XLEN   = 64,
  parameter  int NREG   = 16,
  parameter  int PC_W   = 8,
  parameter  int CTRL_W = 8,
  parameter  int IMM_W  = 8,
  parameter  int PEND_W = 2,
  localparam int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  // upstream instruction
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [PC_W-1:0]   if_pc,
  input  logic [CTRL_W-1:0] if_ctrl,
  input  logic [AW-1:0]     if_rs1,
  input  logic [AW-1:0]     if_rs2,
  input  logic [AW-1:0]     if_rd,
  input  logic              if_uses_rs1,
  input  logic              if_uses_rs2,
  input  logic              if_writes_rd,
  input  logic [IMM_W-1:0]  if_imm,
  // register file read ports
  output logic [AW-1:0]     rf_raddr1,
  output logic [AW-1:0]     rf_raddr2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  // writeback
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  // control
  input  logic              flush,
  // downstream
  output logic              of_valid,
  input  logic              of_ready,
  output logic [PC_W-1:0]   of_pc,
  output logic [CTRL_W-1:0] of_ctrl,
  output logic [IMM_W-1:0]  of_imm,
  output logic [AW-1:0]     of_rd,
  output logic              of_writes_rd,
  output logic [XLEN-1:0]   of_op1,
  output logic [XLEN-1:0]   of_op2,
  output logic [15:0]       stall_count
);

  localparam logic [PEND_W-1:0] c_pend_max = '1;
  localparam logic [15:0]       c_stall_max = 16'hFFFF;

  logic [PEND_W-1:0] r_pend      [NREG];
  logic [PEND_W-1:0] w_pend_next [NREG];
  logic [NREG-1:0]   w_wb_hit;
  logic [NREG-1:0]   w_eff_nz;

  logic              r_of_valid;
  logic [PC_W-1:0]   r_of_pc;
  logic [CTRL_W-1:0] r_of_ctrl;
  logic [IMM_W-1:0]  r_of_imm;
  logic [AW-1:0]     r_of_rd;
  logic              r_of_writes_rd;
  logic [XLEN-1:0]   r_of_op1;
  logic [XLEN-1:0]   r_of_op2;
  logic [15:0]       r_stall_count;

  logic              w_hazard;
  logic              w_if_ready;
  logic              w_accept;
  logic              w_stall_evt;
  logic [XLEN-1:0]   w_op1;
  logic [XLEN-1:0]   w_op2;

  // Per-register scoreboard: writeback credit, effective count and net update.
  // A writeback to a register with no pending writer is ignored, so it never
  // earns credit and the count cannot underflow.
  for (genvar g = 0; g < NREG; g++) begin : g_pend
    logic              w_inc;
    logic              w_dec_fl;
    logic [PEND_W:0]   w_up;
    logic [1:0]        w_dn;

    assign w_wb_hit[g] = wb_valid && (wb_addr == AW'(g)) && (r_pend[g] != '0);
    assign w_eff_nz[g] = (r_pend[g] != '0) &&
                         !(w_wb_hit[g] && (r_pend[g] == PEND_W'(1)));
    assign w_inc       = w_accept && if_writes_rd && (if_rd == AW'(g));
    assign w_dec_fl    = flush && r_of_valid && r_of_writes_rd && (r_of_rd == AW'(g));
    assign w_up        = {1'b0, r_pend[g]} + {{PEND_W{1'b0}}, w_inc};
    assign w_dn        = {1'b0, w_wb_hit[g]} + {1'b0, w_dec_fl};
    // Increment only happens below the all-ones cap, so w_up - w_dn fits.
    assign w_pend_next[g] = (w_up > (PEND_W+1)'(w_dn)) ?
                            PEND_W'(w_up - (PEND_W+1)'(w_dn)) : '0;
  end

  assign w_hazard = (if_uses_rs1  && w_eff_nz[if_rs1]) ||
                    (if_uses_rs2  && w_eff_nz[if_rs2]) ||
                    (if_writes_rd && (r_pend[if_rd] == c_pend_max));

  assign w_if_ready  = !flush && !w_hazard && (!r_of_valid || of_ready);
  assign w_accept    = if_valid && w_if_ready;
  assign w_stall_evt = if_valid && w_hazard && !flush;

  // Same-cycle writeback overrides the (stale) register-file read.
  assign w_op1 = (wb_valid && (wb_addr == if_rs1)) ? wb_data : rf_rdata1;
  assign w_op2 = (wb_valid && (wb_addr == if_rs2)) ? wb_data : rf_rdata2;

  // Scoreboard state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_pend[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) r_pend[i] <= w_pend_next[i];
    end
  end

  // Output register: flush wins, then accept, then drain; otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_of_valid     <= 1'b0;
      r_of_pc        <= '0;
      r_of_ctrl      <= '0;
      r_of_imm       <= '0;
      r_of_rd        <= '0;
      r_of_writes_rd <= 1'b0;
      r_of_op1       <= '0;
      r_of_op2       <= '0;
    end else if (flush) begin
      r_of_valid     <= 1'b0;
    end else if (w_accept) begin
      r_of_valid     <= 1'b1;
      r_of_pc        <= if_pc;
      r_of_ctrl      <= if_ctrl;
      r_of_imm       <= if_imm;
      r_of_rd        <= if_rd;
      r_of_writes_rd <= if_writes_rd;
      r_of_op1       <= w_op1;
      r_of_op2       <= w_op2;
    end else if (r_of_valid && of_ready) begin
      r_of_valid     <= 1'b0;
    end
  end

  // Saturating count of cycles a valid instruction was held back by a hazard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
    end else if (w_stall_evt && (r_stall_count != c_stall_max)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign if_ready     = w_if_ready;
  assign rf_raddr1    = if_rs1;
  assign rf_raddr2    = if_rs2;
  assign of_valid     = r_of_valid;
  assign of_pc        = r_of_pc;
  assign of_ctrl      = r_of_ctrl;
  assign of_imm       = r_of_imm;
  assign of_rd        = r_of_rd;
  assign of_writes_rd = r_of_writes_rd;
  assign of_op1       = r_of_op1;
  assign of_op2       = r_of_op2;
  assign stall_count  = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_fetch_stage
//  Purpose  : Self-checking bench for operand_fetch_stage: directed scenarios
//             followed by random traffic against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_operand_fetch_stage;

  localparam int XLEN = 64, NREG = 16, PC_W = 8, CTRL_W = 8, IMM_W = 8, PEND_W = 2;
  localparam int AW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_valid, if_ready;
  logic [PC_W-1:0]   if_pc;
  logic [CTRL_W-1:0] if_ctrl;
  logic [AW-1:0]     if_rs1, if_rs2, if_rd;
  logic              if_uses_rs1, if_uses_rs2, if_writes_rd;
  logic [IMM_W-1:0]  if_imm;
  logic [AW-1:0]     rf_raddr1, rf_raddr2;
  logic [XLEN-1:0]   rf_rdata1, rf_rdata2;
  logic              wb_valid;
  logic [AW-1:0]     wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              flush;
  logic              of_valid, of_ready;
  logic [PC_W-1:0]   of_pc;
  logic [CTRL_W-1:0] of_ctrl;
  logic [IMM_W-1:0]  of_imm;
  logic [AW-1:0]     of_rd;
  logic              of_writes_rd;
  logic [XLEN-1:0]   of_op1, of_op2;
  logic [15:0]       stall_count;

  // bench-side register file
  logic [XLEN-1:0] rf [NREG];
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  operand_fetch_stage #(
    .XLEN(XLEN), .NREG(NREG), .PC_W(PC_W), .CTRL_W(CTRL_W),
    .IMM_W(IMM_W), .PEND_W(PEND_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_ctrl(if_ctrl),
    .if_rs1(if_rs1), .if_rs2(if_rs2), .if_rd(if_rd),
    .if_uses_rs1(if_uses_rs1), .if_uses_rs2(if_uses_rs2), .if_writes_rd(if_writes_rd),
    .if_imm(if_imm),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush),
    .of_valid(of_valid), .of_ready(of_ready),
    .of_pc(of_pc), .of_ctrl(of_ctrl), .of_imm(of_imm), .of_rd(of_rd),
    .of_writes_rd(of_writes_rd), .of_op1(of_op1), .of_op2(of_op2),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // behavioural model state
  int              m_pend [NREG];
  bit              m_valid, m_wr;
  logic [PC_W-1:0] m_pc;
  logic [7:0]      m_ctrl, m_imm;
  logic [AW-1:0]   m_rd;
  logic [XLEN-1:0] m_op1, m_op2;
  int              m_stall;
  int              n_cmp = 0;
  int              n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count of writers still outstanding once this cycle's writeback is credited.
  function automatic int eff_pend(input int r);
    if (wb_valid && int'(wb_addr) == r && m_pend[r] > 0) return m_pend[r] - 1;
    return m_pend[r];
  endfunction

  function automatic bit m_hazard();
    return (if_uses_rs1  && eff_pend(int'(if_rs1)) != 0) ||
           (if_uses_rs2  && eff_pend(int'(if_rs2)) != 0) ||
           (if_writes_rd && m_pend[int'(if_rd)] == (1 << PEND_W) - 1);
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) m_pend[r] = 0;
    m_valid = 0; m_wr = 0; m_pc = '0; m_ctrl = '0; m_imm = '0; m_rd = '0;
    m_op1 = '0; m_op2 = '0; m_stall = 0;
  endtask

  task automatic check_outputs();
    chk("of_valid", of_valid, m_valid);
    chk("of_pc", of_pc, m_pc);
    chk("of_ctrl", of_ctrl, m_ctrl);
    chk("of_imm", of_imm, m_imm);
    chk("of_rd", of_rd, m_rd);
    chk("of_writes_rd", of_writes_rd, m_wr);
    chk("of_op1", of_op1, m_op1);
    chk("of_op2", of_op2, m_op2);
    chk("stall_count", stall_count, 64'(m_stall));
  endtask

  // One clock cycle: inputs are stable from posedge+1; check combinational
  // outputs mid-cycle, let the edge pass, then advance the model and compare.
  task automatic step();
    bit hz, rdy, acc;
    int p;
    #3;
    hz  = m_hazard();
    rdy = !flush && !hz && (!m_valid || of_ready);
    acc = if_valid && rdy;
    chk("if_ready", if_ready, rdy);
    chk("rf_raddr1", rf_raddr1, if_rs1);
    chk("rf_raddr2", rf_raddr2, if_rs2);
    @(posedge clk);
    #1;
    for (int r = 0; r < NREG; r++) begin
      p = m_pend[r];
      if (acc && if_writes_rd && int'(if_rd) == r) p++;
      if (wb_valid && int'(wb_addr) == r && m_pend[r] > 0) p--;
      if (flush && m_valid && m_wr && int'(m_rd) == r) p--;
      m_pend[r] = (p < 0) ? 0 : p;
    end
    if (if_valid && hz && !flush && m_stall < 65535) m_stall++;
    if (flush) m_valid = 0;
    else if (acc) begin
      m_valid = 1; m_pc = if_pc; m_ctrl = if_ctrl; m_imm = if_imm;
      m_rd = if_rd; m_wr = if_writes_rd;
      m_op1 = (wb_valid && wb_addr == if_rs1) ? wb_data : rf[if_rs1];
      m_op2 = (wb_valid && wb_addr == if_rs2) ? wb_data : rf[if_rs2];
    end else if (m_valid && of_ready) m_valid = 0;
    if (wb_valid) rf[wb_addr] = wb_data;
    check_outputs();
  endtask

  task automatic idle();
    if_valid = 0; if_uses_rs1 = 0; if_uses_rs2 = 0; if_writes_rd = 0;
    if_rs1 = '0; if_rs2 = '0; if_rd = '0; if_pc = '0; if_ctrl = '0; if_imm = '0;
    wb_valid = 0; wb_addr = '0; wb_data = '0; flush = 0; of_ready = 1;
  endtask

  task automatic issue(input int rs1, input int rs2, input int rd,
                       input bit u1, input bit u2, input bit wr);
    if_valid = 1; if_rs1 = AW'(rs1); if_rs2 = AW'(rs2); if_rd = AW'(rd);
    if_uses_rs1 = u1; if_uses_rs2 = u2; if_writes_rd = wr;
    if_pc = PC_W'($urandom); if_ctrl = CTRL_W'($urandom); if_imm = IMM_W'($urandom);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    #2;
    model_clear();
    chk("rst_of_valid", of_valid, 0);
    chk("rst_stall", stall_count, 0);
    chk("rst_of_op1", of_op1, 0);
    chk("rst_of_pc", of_pc, 0);
    @(posedge clk);
    #2;
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int q[$];
    for (int r = 0; r < NREG; r++) rf[r] = {$urandom, $urandom};
    rst_n = 0;
    idle();
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // three independent instructions, full throughput
    for (int k = 1; k <= 3; k++) begin
      issue(k, k + 8, 10 + k, 1, 1, 0);
      step();
      chk("indep_op1", of_op1, rf[k]);
    end
    idle(); step();

    // RAW on r5 released by a same-cycle writeback
    do_reset();
    issue(0, 0, 5, 0, 0, 1); step();
    issue(5, 1, 6, 1, 0, 0);
    for (int k = 0; k < 4; k++) step();
    chk("raw_stall_count", stall_count, 4);
    wb_valid = 1; wb_addr = 4'd5; wb_data = 64'hDEAD_BEEF;
    step();
    chk("raw_fwd_op1", of_op1, 64'hDEAD_BEEF);
    chk("raw_fwd_valid", of_valid, 1);
    idle(); step();

    // WAW capacity: three writers of r2, fourth stalls even with a writeback
    do_reset();
    for (int k = 0; k < 3; k++) begin issue(0, 0, 2, 0, 0, 1); step(); end
    issue(0, 0, 2, 0, 0, 1); step();
    chk("waw_stalled", m_pend[2], 3);
    wb_valid = 1; wb_addr = 4'd2; wb_data = 64'h1234;
    step();
    wb_valid = 0;
    step();
    chk("waw_accepted_rd", of_rd, 2);
    idle(); step();

    // backpressure: held for three cycles, then drain and accept together
    do_reset();
    issue(4, 5, 9, 1, 1, 0); step();
    issue(6, 7, 8, 1, 1, 0); of_ready = 0;
    for (int k = 0; k < 3; k++) step();
    of_ready = 1; step();
    chk("bp_new_op1", of_op1, rf[6]);
    idle(); step();

    // flush of a held writer of r7 returns its pending count
    do_reset();
    issue(0, 0, 7, 0, 0, 1); of_ready = 0; step();
    idle(); flush = 1; of_ready = 0; step();
    flush = 0; of_ready = 1;
    issue(7, 7, 1, 1, 1, 0); step();
    chk("flush_reader_valid", of_valid, 1);
    idle(); step();

    // asynchronous reset in the middle of a stall on r3
    do_reset();
    issue(0, 0, 3, 0, 0, 1); step();
    issue(0, 0, 3, 0, 0, 1); step();
    issue(3, 0, 4, 1, 0, 0); step(); step();
    do_reset();
    issue(3, 0, 4, 1, 0, 0); step();
    chk("post_reset_accept", of_valid, 1);
    idle(); step();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      issue($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
            1'($urandom), 1'($urandom), 1'($urandom));
      if_valid = ($urandom_range(0, 4) != 0);
      q.delete();
      for (int r = 0; r < NREG; r++) if (m_pend[r] > 0) q.push_back(r);
      wb_valid = 0; wb_addr = '0; wb_data = {$urandom, $urandom};
      if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
        wb_valid = 1; wb_addr = AW'(q[$urandom_range(0, q.size() - 1)]);
      end else if ($urandom_range(0, 9) == 0) begin
        wb_valid = 1; wb_addr = AW'($urandom_range(0, 15));
      end
      flush    = ($urandom_range(0, 9) == 0);
      of_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
